axis_i2s_tx: RTL and testbench

- I2S transmitter that consumes the audio formatter's MM2S AXI-Stream (32-bit AES-style words, channel in tid) and serializes stereo PCM onto I2S.
- Runs entirely in the audio master clock domain; the formatter's m_axis_mm2s_* stream connects directly to this block's s_axis_* port.
- Generates the bit clock (sclk), word select (lrclk) and serial data, with a one-pair holding buffer and underrun/channel-error reporting.

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_clkgen.sv | 57 +++++
 rtl/axis_i2s_tx.sv | 162 ++++++++++++++++
 tb/tb_axis_i2s_tx.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the AXI-Stream to I2S transmitter.
// Frame geometry is fixed at two 32-bit slots (64fs bit clock).
package i2s_pkg;

    localparam int SLOT_BITS         = 32;
    localparam int FRAME_BITS        = 64;
    localparam int BIT_CNT_W         = $clog2(FRAME_BITS);
    localparam int DEF_SAMPLE_WIDTH  = 24;

    localparam logic [7:0] CH_LEFT  = 8'd0;
    localparam logic [7:0] CH_RIGHT = 8'd1;

    typedef logic [DEF_SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock divider and frame bit counter. fe, frame_start and bit_cnt describe
// the coming clock edge so the caller can register its outputs in step with sclk.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 sclk,
    output logic                 fe,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 frame_start
);

    localparam int DW = $clog2(SCLK_DIV);

    logic [DW-1:0]        div_cnt_q, div_cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 sclk_q, sclk_d;

    always_comb begin
        fe          = 1'b0;
        frame_start = 1'b0;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sclk_d      = 1'b0;
        if (en) begin
            fe          = (div_cnt_q == DW'(SCLK_DIV - 1));
            frame_start = fe && (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));
            div_cnt_d   = fe ? '0 : div_cnt_q + 1'b1;
            bit_cnt_d   = fe ? bit_cnt_q + 1'b1 : bit_cnt_q;
            // sclk follows the divider value being entered, so it falls on fe.
            sclk_d      = (div_cnt_d >= DW'(SCLK_DIV / 2));
        end else begin
            div_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign sclk    = sclk_q;
    assign bit_cnt = bit_cnt_d;

endmodule

// File: rtl/axis_i2s_tx.sv
// I2S transmitter fed by the audio formatter's MM2S AXI-Stream (channel in tid).
// Holds one L/R pair, loads it at each frame start and serializes MSB first.
module axis_i2s_tx
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV     = 4,
    parameter int SAMPLE_MSB   = 27,
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic        aud_mclk,
    input  logic        aud_mreset,
    input  logic        enable,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tid,
    output logic        i2s_sclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        underrun,
    output logic        chan_err
);

    typedef logic [SAMPLE_WIDTH-1:0] smp_t;

    logic                 fe;
    logic                 frame_start;
    logic [BIT_CNT_W-1:0] bit_cnt;

    logic lv_q, lv_d, rv_q, rv_d;
    smp_t left_q, left_d, right_q, right_d;
    smp_t frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic lrclk_q, lrclk_d, sdata_q, sdata_d;
    logic underrun_q, underrun_d, chan_err_q, chan_err_d;

    logic                 run;
    logic                 accept;
    logic [7:0]           exp_ch;
    smp_t                 sample_in;
    logic [4:0]           pos;
    logic [4:0]           bit_idx;
    logic [SLOT_BITS-1:0] slot_word;
    logic                 unused_tdata;

    i2s_clkgen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_clkgen (
        .clk         (aud_mclk),
        .rst         (aud_mreset),
        .en          (enable),
        .sclk        (i2s_sclk),
        .fe          (fe),
        .bit_cnt     (bit_cnt),
        .frame_start (frame_start)
    );

    assign run           = enable & ~aud_mreset;
    assign s_axis_tready = run & ~(lv_q & rv_q);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign exp_ch        = lv_q ? CH_RIGHT : CH_LEFT;
    assign sample_in     = s_axis_tdata[SAMPLE_MSB -: SAMPLE_WIDTH];
    assign unused_tdata  = ^s_axis_tdata;

    always_comb begin
        lv_d       = lv_q;
        rv_d       = rv_q;
        left_d     = left_q;
        right_d    = right_q;
        frame_l_d  = frame_l_q;
        frame_r_d  = frame_r_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        chan_err_d = 1'b0;
        pos        = bit_cnt[4:0];
        bit_idx    = 5'd0 - pos;
        slot_word  = '0;

        if (accept) begin
            if (s_axis_tid == exp_ch) begin
                if (!lv_q) begin
                    left_d = sample_in;
                    lv_d   = 1'b1;
                end else begin
                    right_d = sample_in;
                    rv_d    = 1'b1;
                end
            end else begin
                chan_err_d = 1'b1;
            end
        end

        // A partial pair survives the boundary; only a full pair is consumed.
        if (frame_start) begin
            if (lv_q && rv_q) begin
                frame_l_d = left_q;
                frame_r_d = right_q;
                lv_d      = 1'b0;
                rv_d      = 1'b0;
            end else begin
                frame_l_d  = '0;
                frame_r_d  = '0;
                underrun_d = 1'b1;
            end
        end

        slot_word = bit_cnt[BIT_CNT_W-1]
                  ? {frame_r_d, {(SLOT_BITS - SAMPLE_WIDTH){1'b0}}}
                  : {frame_l_d, {(SLOT_BITS - SAMPLE_WIDTH){1'b0}}};

        // One-bit delay: position 0 of each slot carries a zero, MSB follows.
        if (fe) begin
            lrclk_d = bit_cnt[BIT_CNT_W-1];
            sdata_d = (pos == 5'd0) ? 1'b0 : slot_word[bit_idx];
        end

        if (!enable) begin
            lv_d       = 1'b0;
            rv_d       = 1'b0;
            left_d     = '0;
            right_d    = '0;
            frame_l_d  = '0;
            frame_r_d  = '0;
            lrclk_d    = 1'b0;
            sdata_d    = 1'b0;
            underrun_d = 1'b0;
            chan_err_d = 1'b0;
        end
    end

    always_ff @(posedge aud_mclk) begin
        if (aud_mreset) begin
            lv_q       <= 1'b0;
            rv_q       <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            frame_l_q  <= '0;
            frame_r_q  <= '0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            chan_err_q <= 1'b0;
        end else begin
            lv_q       <= lv_d;
            rv_q       <= rv_d;
            left_q     <= left_d;
            right_q    <= right_d;
            frame_l_q  <= frame_l_d;
            frame_r_q  <= frame_r_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            chan_err_q <= chan_err_d;
        end
    end

    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;
    assign underrun  = underrun_q;
    assign chan_err  = chan_err_q;

endmodule

// File: tb/tb_axis_i2s_tx.sv
// Bench for axis_i2s_tx: drives AXIS beats, decodes the I2S line at sclk rising
// edges and compares each decoded frame against an expected-frame queue.
module tb_axis_i2s_tx;

    localparam int SW   = 24;
    localparam int SMSB = 27;

    logic        aud_mclk = 1'b0;
    logic        aud_mreset;
    logic        enable;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic [7:0]  s_axis_tid;
    logic        i2s_sclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        underrun;
    logic        chan_err;

    axis_i2s_tx #(
        .SCLK_DIV     (4),
        .SAMPLE_MSB   (SMSB),
        .SAMPLE_WIDTH (SW)
    ) dut (
        .aud_mclk      (aud_mclk),
        .aud_mreset    (aud_mreset),
        .enable        (enable),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tid    (s_axis_tid),
        .i2s_sclk      (i2s_sclk),
        .i2s_lrclk     (i2s_lrclk),
        .i2s_sdata     (i2s_sdata),
        .underrun      (underrun),
        .chan_err      (chan_err)
    );

    // ---------------- clock / reset ----------------
    always #5 aud_mclk = ~aud_mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int          n_checks     = 0;
    int          n_errors     = 0;
    logic [47:0] exp_q[$];
    int          exp_underrun = 0;
    int          exp_chan_err = 0;
    int          underrun_cnt = 0;
    int          chan_err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] smp(input logic [31:0] d);
        return d[SMSB -: SW];
    endfunction

    // ---------------- line monitor ----------------
    int          cyc = 0;
    logic        mon_sclk_p, mon_lr_p, mon_slot_lr;
    bit          rise_ok, fall_ok, lrrise_ok;
    int          last_rise, last_fall, lr_rise_cyc, mon_pos;
    logic [31:0] rx_l, rx_r;

    always @(negedge aud_mclk) begin
        logic [SW-1:0] got_l, got_r;
        logic [47:0]   e;
        cyc++;
        if (aud_mreset || !enable) begin
            mon_sclk_p  = 1'b0;
            mon_lr_p    = 1'b0;
            mon_slot_lr = 1'b0;
            rise_ok     = 1'b0;
            fall_ok     = 1'b0;
            lrrise_ok   = 1'b0;
            mon_pos     = -1;
        end else begin
            if (underrun) begin
                underrun_cnt++;
                chk("underrun_at_boundary", {mon_lr_p, i2s_lrclk}, 2'b10);
            end
            if (chan_err) chan_err_cnt++;
            if (i2s_lrclk && !mon_lr_p) begin
                lr_rise_cyc = cyc;
                lrrise_ok   = 1'b1;
            end
            if (!i2s_lrclk && mon_lr_p) begin
                if (fall_ok)   chk("lrclk_period", cyc - last_fall, 256);
                if (lrrise_ok) chk("lrclk_high", cyc - lr_rise_cyc, 128);
                last_fall = cyc;
                fall_ok   = 1'b1;
            end
            if (i2s_sclk && !mon_sclk_p) begin
                if (rise_ok) chk("sclk_period", cyc - last_rise, 4);
                last_rise = cyc;
                rise_ok   = 1'b1;
                if (i2s_lrclk != mon_slot_lr) begin
                    if (!i2s_lrclk) begin
                        chk("slot_len_r", mon_pos, 31);
                        for (int p = 1; p <= SW; p++) begin
                            got_l[SW-p] = rx_l[p];
                            got_r[SW-p] = rx_r[p];
                        end
                        chk("pad_zero", {rx_l[31:SW+1], rx_l[0], rx_r[31:SW+1], rx_r[0]}, 0);
                        if (exp_q.size() == 0) begin
                            chk("frame_unexpected", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame_left", got_l, e[47:24]);
                            chk("frame_right", got_r, e[23:0]);
                        end
                    end else begin
                        chk("slot_len_l", mon_pos, 31);
                    end
                    mon_slot_lr = i2s_lrclk;
                    mon_pos     = 0;
                end else begin
                    mon_pos++;
                end
                if (mon_pos >= 0 && mon_pos < 32) begin
                    if (mon_slot_lr) rx_r[mon_pos] = i2s_sdata;
                    else             rx_l[mon_pos] = i2s_sdata;
                end
            end
            mon_sclk_p = i2s_sclk;
            mon_lr_p   = i2s_lrclk;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [7:0] tid, input logic [31:0] data, input bit bad);
        int n;
        n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tid    = tid;
        s_axis_tdata  = data;
        while (!s_axis_tready && n < 600) begin
            @(negedge aud_mclk);
            n++;
        end
        if (n >= 600) chk("tready_timeout", 1, 0);
        @(negedge aud_mclk);
        s_axis_tvalid = 1'b0;
        chk(bad ? "chan_err_pulse" : "chan_err_quiet", chan_err, bad);
        if (bad) exp_chan_err++;
    endtask

    task automatic send_pair(input logic [31:0] dl, input logic [31:0] dr);
        send_beat(8'd0, dl, 1'b0);
        send_beat(8'd1, dr, 1'b0);
        exp_q.push_back({smp(dl), smp(dr)});
    endtask

    // Returns at the first negedge after lrclk falls; rdy_before is tready one cycle earlier.
    task automatic wait_boundary(output logic rdy_before, output logic ur_at);
        logic p, r;
        int   n;
        bit   done;
        p    = i2s_lrclk;
        r    = s_axis_tready;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge aud_mclk);
            n++;
            if (p && !i2s_lrclk) begin
                done = 1'b1;
            end else if (n > 600) begin
                chk("boundary_timeout", 1, 0);
                done = 1'b1;
            end else begin
                p = i2s_lrclk;
                r = s_axis_tready;
            end
        end
        rdy_before = r;
        ur_at      = underrun;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        r, u;
        logic [31:0] dl, dr;
        int          n;

        aud_mreset    = 1'b1;
        enable        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tid    = '0;
        repeat (4) @(negedge aud_mclk);
        enable = 1'b1;
        @(negedge aud_mclk);
        chk("reset_outputs", {i2s_sclk, i2s_lrclk, i2s_sdata, underrun, chan_err, s_axis_tready}, 6'b0);

        // Idle stream: frame 0 silent without underrun, frame 1 silent with underrun.
        aud_mreset = 1'b0;
        exp_q.push_back('0);
        exp_q.push_back('0);
        exp_underrun++;
        wait_boundary(r, u);
        chk("first_underrun", u, 1);
        @(negedge aud_mclk);
        chk("underrun_cnt_first", underrun_cnt, 1);

        // Known pair.
        send_pair(32'h0ABCDEF0, 32'h05555550);
        wait_boundary(r, u);
        chk("pair_no_underrun", u, 0);

        // Back-to-back stream of 8 pairs with full-buffer backpressure.
        for (int k = 0; k < 8; k++) begin
            dl = $urandom;
            dr = $urandom;
            if (k > 0) begin
                s_axis_tvalid = 1'b1;
                s_axis_tid    = 8'd0;
                s_axis_tdata  = dl;
                wait_boundary(r, u);
                chk("tready_low_before_load", r, 0);
                chk("tready_after_load", s_axis_tready, 1);
                chk("stream_no_underrun", u, 0);
            end
            send_pair(dl, dr);
            chk("tready_full", s_axis_tready, 0);
        end

        // Wrong-channel beats are dropped; the following pair still plays.
        send_beat(8'd1, $urandom, 1'b1);
        send_beat(8'd5, $urandom, 1'b1);
        send_pair($urandom, $urandom);

        // Left only at the boundary: underrun and silence, then the pair plays.
        dl = $urandom;
        send_beat(8'd0, dl, 1'b0);
        exp_q.push_back('0);
        exp_underrun++;
        wait_boundary(r, u);
        chk("partial_underrun", u, 1);
        chk("partial_ready", s_axis_tready, 1);
        dr = $urandom;
        send_beat(8'd1, dr, 1'b0);
        exp_q.push_back({smp(dl), smp(dr)});

        // Reset mid right slot with a full pair buffered; that pair must be lost.
        wait_boundary(r, u);
        chk("late_pair_no_underrun", u, 0);
        send_beat(8'd0, $urandom, 1'b0);
        send_beat(8'd1, $urandom, 1'b0);
        n = 0;
        while (!i2s_lrclk && n < 400) begin
            @(negedge aud_mclk);
            n++;
        end
        repeat (40) @(negedge aud_mclk);
        aud_mreset = 1'b1;
        @(negedge aud_mclk);
        chk("rst_outputs", {i2s_sclk, i2s_lrclk, i2s_sdata, underrun, chan_err, s_axis_tready}, 6'b0);
        chk("rst_pending_frames", exp_q.size(), 1);
        exp_q.delete();
        repeat (2) @(negedge aud_mclk);
        aud_mreset = 1'b0;
        exp_q.push_back('0);
        exp_q.push_back('0);
        exp_underrun++;
        n = 0;
        while (!i2s_lrclk && n < 400) begin
            @(negedge aud_mclk);
            n++;
        end
        chk("lrclk_rise_after_rst", n, 128);
        wait_boundary(r, u);
        chk("rst_first_underrun", u, 1);
        send_pair($urandom, $urandom);
        exp_q.push_back('0);
        exp_underrun++;
        wait_boundary(r, u);
        wait_boundary(r, u);
        repeat (8) @(negedge aud_mclk);

        chk("exp_last_pending", exp_q.size(), 1);
        chk("underrun_total", underrun_cnt, exp_underrun);
        chk("chan_err_total", chan_err_cnt, exp_chan_err);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
